// File: rtl/pipeline_ctrl_if.sv
// Hazard/flush control bundle between the pipeline datapath and pipeline_ctrl.
//   ID stage : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2 (source operands of the ID instruction)
//   EX stage : ex_rd, ex_memRead, ex_branch_taken       (destination, load flag, branch outcome)
//   IF stage : imem_ready                               (instruction memory data valid)
//   controls : pcWrite, hazDetect_IF_ID, IF_Flush, ID_EX_Flush
//   status   : state, stall_count, flush_count
// master = datapath side (drives stage info), slave = controller side.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memRead;
  logic        ex_branch_taken;
  logic        imem_ready;
  logic        pcWrite;
  logic        hazDetect_IF_ID;
  logic        IF_Flush;
  logic        ID_EX_Flush;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memRead,
           ex_branch_taken, imem_ready,
    input  pcWrite, hazDetect_IF_ID, IF_Flush, ID_EX_Flush, state,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memRead,
           ex_branch_taken, imem_ready,
    output pcWrite, hazDetect_IF_ID, IF_Flush, ID_EX_Flush, state,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard controller for a 5-stage pipeline. Inserts load-use
// bubbles, flushes wrong-path fetches after taken branches and holds the PC
// while instruction memory is not ready. Keeps saturating counts of stall and
// flush cycles.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : pipeline_ctrl_if.slave (stage inputs, control outputs, status)
// Parameters: FLUSH_CYCLES (>=1) IF_Flush cycles per taken branch,
//             LOAD_STALL_CYCLES (>=1) bubbles per load-use hazard.
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYC = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ?
                                    FLUSH_CYCLES : LOAD_STALL_CYCLES;
  // cnt never holds more than MAX_CYC-1.
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STALL      = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_FETCH_WAIT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       stall_count_q, stall_count_d;
  logic [15:0]       flush_count_q, flush_count_d;

  logic load_use;
  logic pc_write, if_id_write, if_flush, id_ex_flush;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    id_ex_flush = 1'b0;

    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    load_use = bus.ex_memRead && (bus.ex_rd != 5'd0) &&
               ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    case (state_q)
      ST_RUN, ST_FETCH_WAIT: begin
        if (bus.ex_branch_taken) begin
          // The first flush cycle happens here; FLUSH covers the remainder.
          if_flush    = 1'b1;
          id_ex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_FETCH_WAIT) begin
          // Load-use is deliberately not evaluated while waiting on fetch.
          if (bus.imem_ready) begin
            state_d = ST_RUN;
          end else begin
            pc_write = 1'b0;
            if_flush = 1'b1;
          end
        end else if (load_use) begin
          // The first bubble happens here; STALL covers the remainder.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_STALL;
            cnt_d   = STALL_RELOAD;
          end
        end else if (!bus.imem_ready) begin
          pc_write = 1'b0;
          if_flush = 1'b1;
          state_d  = ST_FETCH_WAIT;
        end
      end

      ST_STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_FLUSH: begin
        if_flush = 1'b1;
        if (bus.ex_branch_taken) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // While in reset the pipeline is frozen and both pipeline registers load NOPs.
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_flush    = 1'b1;
      id_ex_flush = 1'b1;
    end

    stall_count_d = (!pc_write && (stall_count_q != 16'hFFFF)) ?
                    stall_count_q + 16'd1 : stall_count_q;
    flush_count_d = (if_flush && (flush_count_q != 16'hFFFF)) ?
                    flush_count_q + 16'd1 : flush_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.pcWrite         = pc_write;
  assign bus.hazDetect_IF_ID = if_id_write;
  assign bus.IF_Flush        = if_flush;
  assign bus.ID_EX_Flush     = id_ex_flush;
  assign bus.state           = state_q;
  assign bus.stall_count     = stall_count_q;
  assign bus.flush_count     = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl. Two instances share the same stimulus:
//   dut_a: FLUSH_CYCLES=1, LOAD_STALL_CYCLES=1
//   dut_b: FLUSH_CYCLES=3, LOAD_STALL_CYCLES=4
// Each is compared every cycle against a reference model that tracks
// "bubbles left", "flush cycles left" and "waiting for fetch" directly.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_branch_taken, imem_ready;

  pipeline_ctrl_if if_a ();
  pipeline_ctrl_if if_b ();

  assign if_a.id_rs1 = id_rs1;           assign if_b.id_rs1 = id_rs1;
  assign if_a.id_rs2 = id_rs2;           assign if_b.id_rs2 = id_rs2;
  assign if_a.id_uses_rs1 = id_uses_rs1; assign if_b.id_uses_rs1 = id_uses_rs1;
  assign if_a.id_uses_rs2 = id_uses_rs2; assign if_b.id_uses_rs2 = id_uses_rs2;
  assign if_a.ex_rd = ex_rd;             assign if_b.ex_rd = ex_rd;
  assign if_a.ex_memRead = ex_memRead;   assign if_b.ex_memRead = ex_memRead;
  assign if_a.ex_branch_taken = ex_branch_taken;
  assign if_b.ex_branch_taken = ex_branch_taken;
  assign if_a.imem_ready = imem_ready;   assign if_b.imem_ready = imem_ready;

  pipeline_ctrl #(.FLUSH_CYCLES(1), .LOAD_STALL_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  pipeline_ctrl #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state per instance.
  int p_flush [2] = '{1, 3};
  int p_stall [2] = '{1, 4};
  int m_stall [2], m_flush [2], m_sc [2], m_fc [2];
  bit m_wait  [2];
  int n_stall [2], n_flush [2], n_sc [2], n_fc [2];
  bit n_wait  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_stall[k] = 0; m_flush[k] = 0; m_wait[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // ctl = {pcWrite, hazDetect_IF_ID, IF_Flush, ID_EX_Flush}
  task automatic get_obs(input int k, output logic [3:0] ctl, output logic [1:0] st,
                         output logic [15:0] sc, output logic [15:0] fc);
    if (k == 0) begin
      ctl = {if_a.pcWrite, if_a.hazDetect_IF_ID, if_a.IF_Flush, if_a.ID_EX_Flush};
      st  = if_a.state; sc = if_a.stall_count; fc = if_a.flush_count;
    end else begin
      ctl = {if_b.pcWrite, if_b.hazDetect_IF_ID, if_b.IF_Flush, if_b.ID_EX_Flush};
      st  = if_b.state; sc = if_b.stall_count; fc = if_b.flush_count;
    end
  endtask

  // Expected outputs for this cycle plus the model state after the next edge.
  task automatic model_eval(input int k, output logic [3:0] ctl, output int st);
    bit haz;
    haz = ex_memRead && (ex_rd != 0) &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    n_stall[k] = m_stall[k]; n_flush[k] = m_flush[k]; n_wait[k] = m_wait[k];
    if (m_stall[k] > 0) begin
      st = 1; ctl = 4'b0001; n_stall[k] = m_stall[k] - 1;
    end else if (m_flush[k] > 0) begin
      st = 2; ctl = 4'b1110;
      n_flush[k] = ex_branch_taken ? p_flush[k] - 1 : m_flush[k] - 1;
    end else if (m_wait[k]) begin
      st = 3;
      if (ex_branch_taken) begin
        ctl = 4'b1111; n_flush[k] = p_flush[k] - 1; n_wait[k] = 1'b0;
      end else if (imem_ready) begin
        ctl = 4'b1100; n_wait[k] = 1'b0;
      end else begin
        ctl = 4'b0110;
      end
    end else begin
      st = 0;
      if (ex_branch_taken) begin
        ctl = 4'b1111; n_flush[k] = p_flush[k] - 1;
      end else if (haz) begin
        ctl = 4'b0001; n_stall[k] = p_stall[k] - 1;
      end else if (!imem_ready) begin
        ctl = 4'b0110; n_wait[k] = 1'b1;
      end else begin
        ctl = 4'b1100;
      end
    end
    n_sc[k] = (!ctl[3] && m_sc[k] < 65535) ? m_sc[k] + 1 : m_sc[k];
    n_fc[k] = ( ctl[1] && m_fc[k] < 65535) ? m_fc[k] + 1 : m_fc[k];
  endtask

  task automatic eval_check(input int k);
    logic [3:0]  exp_ctl, got_ctl;
    int          exp_st;
    logic [1:0]  got_st;
    logic [15:0] got_sc, got_fc;
    model_eval(k, exp_ctl, exp_st);
    get_obs(k, got_ctl, got_st, got_sc, got_fc);
    check($sformatf("ctl%0d", k), got_ctl, exp_ctl);
    check($sformatf("state%0d", k), got_st, exp_st);
    check($sformatf("stall_count%0d", k), got_sc, m_sc[k]);
    check($sformatf("flush_count%0d", k), got_fc, m_fc[k]);
  endtask

  task automatic check_in_reset();
    logic [3:0]  got_ctl;
    logic [1:0]  got_st;
    logic [15:0] got_sc, got_fc;
    for (int k = 0; k < 2; k++) begin
      get_obs(k, got_ctl, got_st, got_sc, got_fc);
      check($sformatf("rst_ctl%0d", k), got_ctl, 4'b0011);
      check($sformatf("rst_state%0d", k), got_st, 0);
      check($sformatf("rst_sc%0d", k), got_sc, 0);
      check($sformatf("rst_fc%0d", k), got_fc, 0);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_memRead = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  // One clock: drive after the falling edge, compare, then commit the model.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic rdy);
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_memRead = mr; ex_branch_taken = br; imem_ready = rdy;
    #1;
    eval_check(0);
    eval_check(1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_stall[k] = n_stall[k]; m_flush[k] = n_flush[k]; m_wait[k] = n_wait[k];
      m_sc[k] = n_sc[k]; m_fc[k] = n_fc[k];
    end
  endtask

  task automatic idle_step();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic hazard_step();
    step(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
  endtask

  // Asserts reset right now (between edges), checks it took effect, releases
  // it on the next falling edge.
  task automatic async_reset_now();
    set_idle();
    rst = 1'b1;
    #1;
    check_in_reset();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    async_reset_now();
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    model_reset();
    #3;
    rst = 1'b1;
    #1;
    check_in_reset();
    @(negedge clk);
    #1;
    check_in_reset();
    rst = 1'b0;

    // x0 exclusion: load to x0 with ID reading x0 never stalls.
    step(5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    #2;
    check("x0_stall_count", if_a.stall_count, 0);

    // Single load-use bubble on dut_a.
    hazard_step();
    idle_step();
    #2;
    check("lu_stall_count", if_a.stall_count, 1);
    check("lu_state", if_a.state, 0);
    repeat (5) idle_step();

    // Taken branch: dut_b flushes three cycles, dut_a one.
    reset_pulse();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) idle_step();
    #2;
    check("br_flush_count_b", if_b.flush_count, 3);
    check("br_flush_count_a", if_a.flush_count, 1);

    // Branch + load-use + fetch miss together: branch wins.
    reset_pulse();
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #2;
    check("simul_state_a", if_a.state, 0);
    check("simul_state_b", if_b.state, 2);
    repeat (4) idle_step();

    // Fetch wait for four cycles, then a branch in the middle of a wait.
    reset_pulse();
    repeat (4) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle_step();
    #2;
    check("fw_stall_count", if_a.stall_count, 4);
    check("fw_state", if_a.state, 0);
    repeat (2) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (4) idle_step();

    // Reset in the middle of a 4-cycle stall on dut_b.
    reset_pulse();
    hazard_step();
    idle_step();
    #2;
    check("mid_stall_state_b", if_b.state, 1);
    async_reset_now();
    idle_step();
    idle_step();

    // Randomized traffic with a small register range so hazards are common.
    for (int i = 0; i < 3000; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end

    // Drive stall_count to saturation and past it.
    reset_pulse();
    repeat (65536) hazard_step();
    #2;
    check("sat_stall_count", if_a.stall_count, 16'hFFFF);
    repeat (3) hazard_step();
    #2;
    check("sat_stall_hold", if_a.stall_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning).
  FLUSH_CYCLES       1   consecutive IF_Flush cycles per taken branch, legal range >=1
  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard, legal range >=1
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
  clk              in   1   single clock, all state on rising edge
  rst              in   1   reset, asynchronous, active-high
  id_rs1           in   5   rs1 of the instruction in ID
  id_rs2           in   5   rs2 of the instruction in ID
  id_uses_rs1      in   1   ID instruction reads rs1
  id_uses_rs2      in   1   ID instruction reads rs2
  ex_rd            in   5   destination register of the instruction in EX
  ex_memRead       in   1   EX instruction is a load
  ex_branch_taken  in   1   branch/jump resolved taken in EX this cycle
  imem_ready       in   1   instruction memory data valid this cycle
  pcWrite          out  1   1 = PC loads its next value
  hazDetect_IF_ID  out  1   IF/ID write enable, 1 = load
  IF_Flush         out  1   1 = IF/ID loads zeros (NOP)
  ID_EX_Flush      out  1   1 = ID/EX loads a bubble
  state            out  2   FSM state: 0 RUN, 1 STALL, 2 FLUSH, 3 FETCH_WAIT
  stall_count      out  16  cycles with pcWrite=0, saturating
  flush_count      out  16  cycles with IF_Flush=1, saturating

Function
REQ-003 Outputs pcWrite, hazDetect_IF_ID, IF_Flush and ID_EX_Flush SHALL be combinational from state, the internal down-counter cnt and the current inputs; state, cnt and both count outputs SHALL be registered.
REQ-004 The load-use hazard SHALL be defined as ex_memRead & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-005 Event priority in RUN SHALL be: ex_branch_taken, then load-use, then !imem_ready.
REQ-006 RUN with no event SHALL drive pcWrite=1, hazDetect_IF_ID=1, IF_Flush=0 and ID_EX_Flush=0, and SHALL remain in RUN.
REQ-007 RUN with taken branch SHALL drive pcWrite=1, hazDetect_IF_ID=1, IF_Flush=1 and ID_EX_Flush=1; next state FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-008 RUN with load-use SHALL drive pcWrite=0, hazDetect_IF_ID=0, IF_Flush=0 and ID_EX_Flush=1; next state STALL with cnt=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, else RUN.
REQ-009 RUN with !imem_ready SHALL drive pcWrite=0, hazDetect_IF_ID=1, IF_Flush=1 and ID_EX_Flush=0; next state FETCH_WAIT.
REQ-010 STALL SHALL drive pcWrite=0, hazDetect_IF_ID=0 and ID_EX_Flush=1, and SHALL decrement cnt; it SHALL enter RUN in the cycle after cnt reaches 1, so that total bubbles equal LOAD_STALL_CYCLES; ex_branch_taken SHALL be ignored in STALL.
REQ-011 FLUSH SHALL drive pcWrite=1, hazDetect_IF_ID=1, IF_Flush=1 and ID_EX_Flush=0, and SHALL decrement cnt; it SHALL return to RUN after cnt reaches 1; ex_branch_taken in FLUSH SHALL reload cnt=FLUSH_CYCLES-1.
REQ-012 FETCH_WAIT SHALL use the following priority.
  - ex_branch_taken: behave as REQ-007.
  - else imem_ready=1: drive pcWrite=1, hazDetect_IF_ID=1 and both flushes 0; next state RUN.
  - else: hold the outputs of REQ-009.
  - The load-use check SHALL NOT be evaluated in FETCH_WAIT.
REQ-013 stall_count SHALL increment on each clock edge where pcWrite=0 and rst=0, and SHALL saturate at 16'hFFFF.
REQ-014 flush_count SHALL increment on each clock edge where IF_Flush=1 and rst=0, and SHALL saturate at 16'hFFFF.
REQ-015 Each counter SHALL increment by at most 1 per cycle.

Reset
REQ-016 rst=1 SHALL immediately force state=RUN, cnt=0, stall_count=0 and flush_count=0, independent of clk.
REQ-017 While rst=1, the block SHALL drive pcWrite=0, hazDetect_IF_ID=0, IF_Flush=1 and ID_EX_Flush=1.
REQ-018 Reset asserted mid-STALL, mid-FLUSH or mid-FETCH_WAIT SHALL abandon the sequence; the first cycle after release SHALL be RUN.

Verification
REQ-019 Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle with pcWrite=0, hazDetect_IF_ID=0 and ID_EX_Flush=1; next cycle RUN; stall_count=1.
REQ-020 x0 exclusion: ex_memRead=1, ex_rd=0, id_rs1=0 -> no stall; pcWrite stays 1.
REQ-021 Branch with FLUSH_CYCLES=3: pulse ex_branch_taken -> IF_Flush=1 for exactly 3 cycles and ID_EX_Flush=1 only in the first; flush_count=3.
REQ-022 Simultaneous events: taken branch plus load-use plus imem_ready=0 in one cycle -> branch wins (pcWrite=1, IF_Flush=1); next state FLUSH or RUN per FLUSH_CYCLES.
REQ-023 Fetch wait: imem_ready=0 for 4 cycles -> pcWrite=0 and IF_Flush=1 for 4 cycles, then RUN; stall_count=4; taken branch mid-wait -> pcWrite=1 that cycle.
REQ-024 Reset and saturation: assert rst asynchronously in STALL with LOAD_STALL_CYCLES=4 -> state=0 and counters 0 immediately; preloading stall_count to FFFF and stalling again -> stall_count stays FFFF.
